// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multiport register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int REGFILE_WIDTH = 32;
    localparam int REGFILE_DEPTH = 32;
    localparam int REGFILE_NREAD = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks entries 1..DEPTH-1, one per cycle, after a Clear pulse.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = REGFILE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    output logic          busy,
    output logic          clear_en,
    output logic [AW-1:0] clear_idx
);

    clr_state_e    state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Entry 0 is never stored, so the walk starts at 1 and ends on DEPTH-1.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = AW'(1);
                end
            end
            CLEAR: begin
                idx_nxt = idx + AW'(1);
                if (idx == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == CLEAR);
    assign clear_en  = (state == CLEAR);
    assign clear_idx = idx;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NREAD registered read ports, one write port, entry 0 reads zero.
// Define REGFILE_BYPASS_EN for write-first same-edge reads; read-first otherwise.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int WIDTH = REGFILE_WIDTH,
    parameter  int DEPTH = REGFILE_DEPTH,
    parameter  int NREAD = REGFILE_NREAD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   RegWrite,
    input  logic [AW-1:0]          WriteRegister,
    input  logic [WIDTH-1:0]       WriteData,
    input  logic [NREAD*AW-1:0]    ReadRegister,
    output logic [NREAD*WIDTH-1:0] ReadData,
    input  logic                   Clear,
    output logic                   Busy
);

    logic             clear_en;
    logic [AW-1:0]    clear_idx;
    logic             wr_en;
    logic [WIDTH-1:0] mem   [1:DEPTH-1];
    logic [WIDTH-1:0] entry [DEPTH];

    regfile_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear (
        .clk       (Clk),
        .rst       (Reset),
        .clear_req (Clear),
        .busy      (Busy),
        .clear_en  (clear_en),
        .clear_idx (clear_idx)
    );

    // A Clear request on the same edge as a write takes priority over it.
    assign wr_en = RegWrite && !Busy && !Clear && (WriteRegister != '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear_en) begin
            mem[clear_idx] <= '0;
        end else if (wr_en) begin
            mem[WriteRegister] <= WriteData;
        end
    end

    // Full-depth view with a constant-zero slot 0 so read muxes need no special case.
    always_comb begin
        entry[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            entry[i] = mem[i];
        end
    end

    function automatic logic [WIDTH-1:0] read_sel(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] val;
        val = entry[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (WriteRegister == addr)) begin
            val = WriteData;
        end else if (clear_en && (clear_idx == addr)) begin
            val = '0;
        end
`endif
        return val;
    endfunction

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [WIDTH-1:0] rd_data_p1;

        // Read stage: address sampled at the edge, data valid after it.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                rd_data_p1 <= '0;
            end else begin
                rd_data_p1 <= read_sel(ReadRegister[p*AW +: AW]);
            end
        end

        assign ReadData[p*WIDTH +: WIDTH] = rd_data_p1;
    end

endmodule
